// File: rtl/seg_scan_display.sv
// seg_scan_display: scans one selected 32-bit probe word onto an 8-digit
// active-low seven-segment display. The word is snapshotted once per frame.
//
// Ports:
//   clk1        board clock, all state on posedge
//   rst         asynchronous reset, active low
//   display     source select (7 shows zero)
//   src_bus     eight packed 32-bit sources, source i at [32*i +: 32]
//   hold        keep the previous snapshot at the next frame start
//   AN          digit enables, active low
//   SEG         {dp,g,f,e,d,c,b,a}, active low
//   frame_tick  one-cycle pulse when digit 0 of a new frame is driven
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros.

module seg_scan_display #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic [2:0]   display,
    input  logic [255:0] src_bus,
    input  logic         hold,
    output logic [7:0]   AN,
    output logic [7:0]   SEG,
    output logic         frame_tick
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 16'd1);

    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       digit;
    logic [31:0]      snap;
    logic             active;

    logic             tick;
    logic             frame_start;
    logic [31:0]      src_word;
    logic [31:0]      snap_nxt;
    logic [2:0]       digit_nxt;
    logic             active_nxt;
    logic [3:0]       nib;
    logic             blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]       lead;
`endif

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        s = 8'hFF;
        unique case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Outputs are computed from the next-state snapshot and digit so the
    // first digit of a frame already reflects the freshly captured word.
    always_comb begin
        tick        = (div_cnt == DIV_LAST);
        frame_start = tick && (digit == 3'd7);
        src_word    = (display == 3'd7) ? 32'h0
                                        : src_bus[{display, 5'b0} +: 32];
        snap_nxt    = snap;
        if (frame_start && !hold)
            snap_nxt = src_word;
        digit_nxt   = digit + 3'd1;
        active_nxt  = active || frame_start;
        nib         = snap_nxt[{digit_nxt, 2'b0} +: 4];
        blank       = !active_nxt;
`ifdef LEADING_ZERO_BLANK_EN
        // Index of the most significant nonzero nibble; 0 when snap is 0,
        // so digit 0 is never blanked.
        lead = 3'd0;
        for (int i = 1; i < 8; i++)
            if (snap_nxt[4*i +: 4] != 4'h0)
                lead = 3'(i);
        if (digit_nxt > lead)
            blank = 1'b1;
`endif
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            digit      <= 3'd7;
            snap       <= 32'h0;
            active     <= 1'b0;
            AN         <= 8'hFF;
            SEG        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            div_cnt    <= tick ? '0 : div_cnt + CNT_W'(1);
            if (tick) begin
                digit  <= digit_nxt;
                snap   <= snap_nxt;
                active <= active_nxt;
                AN     <= blank ? 8'hFF : ~(8'b1 << digit_nxt);
                SEG    <= blank ? 8'hFF : hex_seg(nib);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of scan timing, snapshot, hold,
// select changes, async reset and SCAN_DIV=1 wrap.

module tb_seg_scan_display;

    logic         clk1;
    logic         rst;
    logic [2:0]   display;
    logic [255:0] src_bus;
    logic         hold;
    logic [7:0]   an0, seg0, an1, seg1;
    logic         ft0, ft1;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] cur;

    logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                               8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] lo_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                               8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] fs_tab [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6,
                               8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] sc_tab [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    seg_scan_display #(.SCAN_DIV(16'd4), .CNT_W(16)) dut0 (
        .clk1(clk1), .rst(rst), .display(display), .src_bus(src_bus),
        .hold(hold), .AN(an0), .SEG(seg0), .frame_tick(ft0)
    );

    seg_scan_display #(.SCAN_DIV(16'd1), .CNT_W(16)) dut1 (
        .clk1(clk1), .rst(rst), .display(display), .src_bus(src_bus),
        .hold(hold), .AN(an1), .SEG(seg1), .frame_tick(ft1)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic step_slot();
        repeat (4) @(posedge clk1);
        #1;
        cur = cur + 3'd1;
    endtask

    task automatic goto_digit(input logic [2:0] d);
        while (cur != d) step_slot();
    endtask

    task automatic test_reset();
        rst = 1'b0; display = 3'd0; src_bus = '0; hold = 1'b0;
        #12;
        n_cmp++;
        if (an0 !== 8'hFF || seg0 !== 8'hFF || ft0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out got %h/%h/%b want FF/FF/0",
                     an0, seg0, ft0);
        end
        repeat (3) @(posedge clk1);
        #1;
        n_cmp++;
        if (an0 !== 8'hFF || an1 !== 8'hFF || seg1 !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_held got %h/%h/%h want FF/FF/FF",
                     an0, an1, seg1);
        end
    endtask

    task automatic test_first_frame();
        display = 3'd6;
        src_bus[32*6 +: 32] = 32'h0040_0010;
        @(negedge clk1);
        rst = 1'b1;
        cur = 3'd7;
        step_slot();
        n_cmp++;
        if (an0 !== 8'hFE || seg0 !== 8'hC0 || ft0 !== 1'b1) begin
            n_err++;
            $display("FAIL first_tick got %h/%h/%b want FE/C0/1",
                     an0, seg0, ft0);
        end
        step_slot();
        n_cmp++;
        if (an0 !== 8'hFD || seg0 !== 8'hF9 || ft0 !== 1'b0) begin
            n_err++;
            $display("FAIL second_tick got %h/%h/%b want FD/F9/0",
                     an0, seg0, ft0);
        end
    endtask

    task automatic test_full_scan();
        src_bus[32*6 +: 32] = 32'h89AB_CDEF;
        goto_digit(3'd7);
        for (int i = 0; i < 8; i++) begin
            step_slot();
            n_cmp++;
            if (an0 !== an_tab[i] || seg0 !== fs_tab[i]
                || ft0 !== (i == 0)) begin
                n_err++;
                $display("FAIL full_scan d%0d got %h/%h/%b want %h/%h/%b",
                         i, an0, seg0, ft0, an_tab[i], fs_tab[i], i == 0);
            end
        end
        step_slot();
        n_cmp++;
        if (an0 !== 8'hFE || ft0 !== 1'b1) begin
            n_err++;
            $display("FAIL scan_wrap got %h/%b want FE/1", an0, ft0);
        end
    endtask

    task automatic test_select_change();
        display = 3'd1;
        src_bus[32*1 +: 32] = 32'h1234_5678;
        src_bus[32*2 +: 32] = 32'hFEDC_BA9C;
        goto_digit(3'd7);
        step_slot();
        n_cmp++;
        if (seg0 !== 8'h80 || ft0 !== 1'b1) begin
            n_err++;
            $display("FAIL sel_src1_d0 got %h/%b want 80/1", seg0, ft0);
        end
        goto_digit(3'd3);
        display = 3'd2;
        for (int i = 0; i < 4; i++) begin
            step_slot();
            n_cmp++;
            if (seg0 !== sc_tab[i] || an0 !== an_tab[i+4]) begin
                n_err++;
                $display("FAIL sel_mid d%0d got %h/%h want %h/%h",
                         i + 4, an0, seg0, an_tab[i+4], sc_tab[i]);
            end
        end
        step_slot();
        n_cmp++;
        if (seg0 !== 8'hC6 || an0 !== 8'hFE || ft0 !== 1'b1) begin
            n_err++;
            $display("FAIL sel_src2 got %h/%h/%b want FE/C6/1",
                     an0, seg0, ft0);
        end
    endtask

    task automatic test_hold();
        display = 3'd6;
        src_bus[32*6 +: 32] = 32'h0000_0010;
        goto_digit(3'd7);
        step_slot();
        n_cmp++;
        if (seg0 !== 8'hC0) begin
            n_err++;
            $display("FAIL hold_load got %h want C0", seg0);
        end
        hold = 1'b1;
        display = 3'd1;
        src_bus[32*6 +: 32] = 32'h0000_0020;
        goto_digit(3'd7);
        step_slot();
        n_cmp++;
        if (ft0 !== 1'b1 || seg0 !== 8'hC0) begin
            n_err++;
            $display("FAIL hold_frame got %b/%h want 1/C0", ft0, seg0);
        end
        step_slot();
        n_cmp++;
        if (seg0 !== 8'hF9 || an0 !== 8'hFD) begin
            n_err++;
            $display("FAIL hold_keep got %h/%h want FD/F9", an0, seg0);
        end
        hold = 1'b0;
        display = 3'd6;
        goto_digit(3'd7);
        step_slot();
        step_slot();
        n_cmp++;
        if (seg0 !== 8'hA4 || an0 !== 8'hFD) begin
            n_err++;
            $display("FAIL hold_release got %h/%h want FD/A4", an0, seg0);
        end
    endtask

    task automatic test_blanking();
        logic [7:0] ea, es;
        src_bus[32*6 +: 32] = 32'h0000_002A;
        goto_digit(3'd7);
        step_slot();
        n_cmp++;
        if (an0 !== 8'hFE || seg0 !== 8'h88) begin
            n_err++;
            $display("FAIL blank_d0 got %h/%h want FE/88", an0, seg0);
        end
        step_slot();
        n_cmp++;
        if (an0 !== 8'hFD || seg0 !== 8'hA4) begin
            n_err++;
            $display("FAIL blank_d1 got %h/%h want FD/A4", an0, seg0);
        end
        for (int i = 2; i < 8; i++) begin
            step_slot();
`ifdef LEADING_ZERO_BLANK_EN
            ea = 8'hFF;
            es = 8'hFF;
`else
            ea = an_tab[i];
            es = 8'hC0;
`endif
            n_cmp++;
            if (an0 !== ea || seg0 !== es) begin
                n_err++;
                $display("FAIL blank_d%0d got %h/%h want %h/%h",
                         i, an0, seg0, ea, es);
            end
        end
    endtask

    task automatic test_async_reset();
        goto_digit(3'd5);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (an0 !== 8'hFF || seg0 !== 8'hFF || ft0 !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst got %h/%h/%b want FF/FF/0",
                     an0, seg0, ft0);
        end
        n_cmp++;
        if (an1 !== 8'hFF || seg1 !== 8'hFF) begin
            n_err++;
            $display("FAIL async_rst1 got %h/%h want FF/FF", an1, seg1);
        end
        src_bus[32*6 +: 32] = 32'h0000_000B;
        @(posedge clk1);
        @(negedge clk1);
        rst = 1'b1;
        cur = 3'd7;
        step_slot();
        n_cmp++;
        if (an0 !== 8'hFE || seg0 !== 8'h83 || ft0 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_restart got %h/%h/%b want FE/83/1",
                     an0, seg0, ft0);
        end
    endtask

    task automatic test_scan_div1();
        rst = 1'b0;
        display = 3'd6;
        hold = 1'b0;
        src_bus[32*6 +: 32] = 32'h7654_3210;
        @(negedge clk1);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk1);
            #1;
            n_cmp++;
            if (an1 !== an_tab[k%8] || seg1 !== lo_tab[k%8]
                || ft1 !== (k % 8 == 0)) begin
                n_err++;
                $display("FAIL div1 k%0d got %h/%h/%b want %h/%h/%b",
                         k, an1, seg1, ft1, an_tab[k%8], lo_tab[k%8],
                         k % 8 == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_full_scan();
        test_select_change();
        test_hold();
        test_blanking();
        test_async_reset();
        test_scan_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
